// File: rtl/uart_pkg.sv
// Shared UART receiver types and constants.
package uart_pkg;

   localparam int unsigned CLKS_PER_BIT_DEFAULT = 434;  // 50 MHz / 115200

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      STOP,
      BREAK
   } rx_state_t;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous bit with a parameterised reset value.
module sync_2ff #(
   parameter logic RST_VAL = 1'b1
) (
   input  logic i_clk,
   input  logic i_rst_n,
   input  logic i_d,
   output logic o_q
);

   logic r_meta;
   logic r_sync;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_meta <= RST_VAL;
         r_sync <= RST_VAL;
      end else begin
         r_meta <= i_d;
         r_sync <= r_meta;
      end
   end

   assign o_q = r_sync;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: mid-bit sampling, one-cycle strobe on a good byte,
// framing-error pulse on a low stop bit, and break hold until the line returns high.
module uart_rx
   import uart_pkg::*;
#(
   parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       rx,
   output logic [7:0] data_out,
   output logic       en,
   output logic       framing_err,
   output logic       busy
);

   localparam int unsigned   CNT_W    = $clog2(CLKS_PER_BIT);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'((CLKS_PER_BIT - 1) / 2);

   logic             w_rx_sync;
   rx_state_t        r_state,   w_state_nxt;
   logic [CNT_W-1:0] r_cnt,     w_cnt_nxt;
   logic [2:0]       r_bit_idx, w_bit_idx_nxt;
   logic [7:0]       r_shift,   w_shift_nxt;
   logic [7:0]       r_data,    w_data_nxt;
   logic             r_en,      w_en_nxt;
   logic             r_ferr,    w_ferr_nxt;

   sync_2ff #(.RST_VAL(1'b1)) u_rx_sync (
      .i_clk   (clk),
      .i_rst_n (rst),
      .i_d     (rx),
      .o_q     (w_rx_sync)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state   <= IDLE;
         r_cnt     <= '0;
         r_bit_idx <= '0;
         r_shift   <= '0;
         r_data    <= '0;
         r_en      <= 1'b0;
         r_ferr    <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_cnt     <= w_cnt_nxt;
         r_bit_idx <= w_bit_idx_nxt;
         r_shift   <= w_shift_nxt;
         r_data    <= w_data_nxt;
         r_en      <= w_en_nxt;
         r_ferr    <= w_ferr_nxt;
      end
   end

   always_comb begin
      w_state_nxt   = r_state;
      w_cnt_nxt     = r_cnt;
      w_bit_idx_nxt = r_bit_idx;
      w_shift_nxt   = r_shift;
      w_data_nxt    = r_data;
      w_en_nxt      = 1'b0;
      w_ferr_nxt    = 1'b0;

      unique case (r_state)
         IDLE: begin
            w_cnt_nxt     = '0;
            w_bit_idx_nxt = '0;
            if (!w_rx_sync) w_state_nxt = START;
         end
         START: begin
            // Re-check the line half a bit in; a short low pulse is a glitch.
            if (r_cnt == CNT_HALF) begin
               w_cnt_nxt   = '0;
               w_state_nxt = w_rx_sync ? IDLE : DATA;
            end else begin
               w_cnt_nxt = r_cnt + 1'b1;
            end
         end
         DATA: begin
            if (r_cnt == CNT_LAST) begin
               w_cnt_nxt              = '0;
               w_shift_nxt[r_bit_idx] = w_rx_sync;
               w_bit_idx_nxt          = r_bit_idx + 1'b1;
               if (r_bit_idx == 3'd7) w_state_nxt = STOP;
            end else begin
               w_cnt_nxt = r_cnt + 1'b1;
            end
         end
         STOP: begin
            if (r_cnt == CNT_LAST) begin
               w_cnt_nxt = '0;
               if (w_rx_sync) begin
                  w_data_nxt  = r_shift;
                  w_en_nxt    = 1'b1;
                  w_state_nxt = IDLE;
               end else begin
                  w_ferr_nxt  = 1'b1;
                  w_state_nxt = BREAK;
               end
            end else begin
               w_cnt_nxt = r_cnt + 1'b1;
            end
         end
         BREAK: begin
            w_cnt_nxt = '0;
            if (w_rx_sync) w_state_nxt = IDLE;
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   assign data_out    = r_data;
   assign en          = r_en;
   assign framing_err = r_ferr;
   assign busy        = (r_state != IDLE);

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 434, meaning clk cycles per serial bit (50 MHz / 115200); legal values are 4 or greater.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all logic is rising-edge.
REQ-003 SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port rx, input, 1 bit: asynchronous serial line, idle high, 8N1, LSB first.
REQ-005 SHALL have port data_out, output, 8 bits: last correctly framed byte, held until the next good byte.
REQ-006 SHALL have port en, output, 1 bit: one-cycle high pulse marking data_out as new; this is the write strobe to the instruction-memory loader.
REQ-007 SHALL have port framing_err, output, 1 bit: one-cycle pulse when a stop bit samples low.
REQ-008 SHALL have port busy, output, 1 bit: high whenever the state is not IDLE.

Function
REQ-009 SHALL pass rx through a two-flop synchronizer (rx_sync) before any use; both flops reset to 1.
REQ-010 SHALL implement states IDLE, START, DATA, STOP, BREAK.
REQ-011 IDLE: SHALL move to START with bit counter = 0 when rx_sync = 0.
REQ-012 START: SHALL count to (CLKS_PER_BIT-1)/2 (integer division); if rx_sync = 0 then -> DATA, else (glitch) -> IDLE; no outputs pulse.
REQ-013 DATA: SHALL sample rx_sync each time the counter reaches CLKS_PER_BIT-1, shift it into bit index 0..7 (LSB first), and clear the counter.
REQ-014 DATA: SHALL move to STOP after the 8th sample.
REQ-015 STOP: SHALL sample rx_sync when the counter reaches CLKS_PER_BIT-1.
REQ-016 STOP, sample = 1: SHALL load data_out from the shift register, pulse en for exactly 1 cycle, and go to IDLE.
REQ-017 STOP, sample = 0: SHALL leave data_out unchanged, pulse framing_err for 1 cycle, and go to BREAK.
REQ-018 BREAK: SHALL stay until rx_sync = 1, then -> IDLE; a held-low line SHALL NOT start a new frame.
REQ-019 Latency: en SHALL rise CLKS_PER_BIT*9 + (CLKS_PER_BIT-1)/2 + 2 (±1) cycles after the start falling edge on rx.
REQ-020 Back-to-back frames (start bit immediately after stop bit) SHALL all be received without loss.
REQ-021 en and framing_err SHALL never be high in the same cycle.
REQ-022 Counter width SHALL be $clog2(CLKS_PER_BIT); the counter SHALL never exceed CLKS_PER_BIT-1.

Reset
REQ-023 While rst = 0 and asynchronously: state = IDLE, counter = 0, bit index = 0, shift register = 0, data_out = 8'h00, en = 0, framing_err = 0, busy = 0.
REQ-024 Reset asserted mid-frame SHALL abort the frame with no pulse.
REQ-025 After reset releases, the first rx falling edge SHALL be treated as a start bit.

Structure
REQ-026 Shared package uart_pkg SHALL hold the state enum (rx_state_t) and the default CLKS_PER_BIT constant.
REQ-027 The synchronizer SHALL be a sub-module named sync_2ff (1-bit, reset value parameterised).
REQ-028 Everything else SHALL reside in uart_rx, with no memories.

Verification (bench CLKS_PER_BIT = 16)
REQ-029 Send byte 8'hA5 with a good stop bit -> exactly one en pulse, data_out = 8'hA5, framing_err = 0, busy low after.
REQ-030 Send 8'h01, 8'hFF, 8'h00 back-to-back -> three en pulses with data_out 8'h01, 8'hFF, 8'h00 in order.
REQ-031 Drive rx low for 5 cycles then high -> no en, no framing_err, busy returns to 0 within 12 cycles.
REQ-032 Send 8'h3C with stop bit low, then hold rx low for 40 cycles, then send 8'h7E -> one framing_err pulse, data_out stays at the prior value until 8'h7E; no spurious frame during the low hold.
REQ-033 Assert rst at bit 4 of 8'hC3, release, then send 8'h5A -> no pulse for the aborted frame, all outputs at reset values, then en with data_out = 8'h5A.
REQ-034 Connect the bench to the instruction-memory loader and send 5 bytes 8'h10..8'h14 -> loader location 4 = 8'h14.
